// File: rtl/multicycle_main_control.sv
// Multicycle main-control FSM for the 16-bit MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives AluOP and the datapath strobes, and counts retired instructions.
module multicycle_main_control #(
  parameter int OPC_W  = 4,
  parameter int FUNC_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic              mem_ready,
  input  logic              alu_zero,
  output logic [OPC_W-1:0]  alu_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic              iord,
  output logic              ir_write,
  output logic              pc_inc,
  output logic              pc_branch,
  output logic              pc_jump,
  output logic              pc_jr,
  output logic              reg_write,
  output logic              link,
  output logic              mem_to_reg,
  output logic              illegal_op,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [OPC_W-1:0]  OpR       = OPC_W'(0);
  localparam logic [OPC_W-1:0]  OpAddi    = OPC_W'(1);
  localparam logic [OPC_W-1:0]  OpLw      = OPC_W'(2);
  localparam logic [OPC_W-1:0]  OpSw      = OPC_W'(3);
  localparam logic [OPC_W-1:0]  OpBeq     = OPC_W'(4);
  localparam logic [OPC_W-1:0]  OpBne     = OPC_W'(5);
  localparam logic [OPC_W-1:0]  OpJ       = OPC_W'(7);
  localparam logic [OPC_W-1:0]  OpJal     = OPC_W'(8);
  localparam logic [OPC_W-1:0]  OpIllegal = OPC_W'(11);
  localparam logic [FUNC_W-1:0] FuncJr    = FUNC_W'(8);

  state_t state, nextState;
  logic   retire;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= nextState;
      if (retire) retired <= retired + 1'b1;
    end
  end

  assign state_o = state;

  // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    nextState  = state;
    retire     = 1'b0;
    alu_op     = opcode;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    pc_jump    = 1'b0;
    pc_jr      = 1'b0;
    reg_write  = 1'b0;
    link       = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;

    case (state)
      FETCH: begin
        alu_op  = OpAddi;
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_inc    = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        if (opcode >= OpIllegal) begin
          illegal_op = 1'b1;
          nextState  = FETCH;
        end else if (opcode == OpJ || opcode == OpJal) begin
          pc_jump   = 1'b1;
          reg_write = (opcode == OpJal);
          link      = (opcode == OpJal);
          retire    = 1'b1;
          nextState = FETCH;
        end else if (opcode == OpR && func == FuncJr) begin
          pc_jr     = 1'b1;
          retire    = 1'b1;
          nextState = FETCH;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        if (opcode == OpBeq || opcode == OpBne) begin
          pc_branch = (opcode == OpBeq) ? alu_zero : !alu_zero;
          retire    = 1'b1;
          nextState = FETCH;
        end else if (opcode == OpLw || opcode == OpSw) begin
          nextState = MEM;
        end else begin
          nextState = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OpSw);
        if (mem_ready) begin
          retire    = (opcode == OpSw);
          nextState = (opcode == OpSw) ? FETCH : WB;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OpLw);
        retire     = 1'b1;
        nextState  = FETCH;
      end
      default: begin
        alu_op    = '0;
        nextState = FETCH;
      end
    endcase

    // Reset must silence the strobes at once, without waiting for a clock edge.
    if (!rst_n) begin
      alu_op     = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_inc     = 1'b0;
      pc_branch  = 1'b0;
      pc_jump    = 1'b0;
      pc_jr      = 1'b0;
      reg_write  = 1'b0;
      link       = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: each instruction is expanded into its expected
// per-cycle output trace from the instruction-level rules, then replayed against the DUT.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        mem_ready;
  logic        alu_zero;
  logic [3:0]  alu_op;
  logic        mem_req, mem_we, iord, ir_write, pc_inc, pc_branch, pc_jump, pc_jr;
  logic        reg_write, link, mem_to_reg, illegal_op;
  logic [2:0]  state_o;
  logic [15:0] retired;

  // Second instance with a 4-bit counter so counter wrap is reachable in a short run.
  logic [3:0]  sAluOp;
  logic        sMemReq, sMemWe, sIord, sIrWrite, sPcInc, sPcBranch, sPcJump, sPcJr;
  logic        sRegWrite, sLink, sMemToReg, sIllegalOp;
  logic [2:0]  sState;
  logic [3:0]  sRetired;

  always #5 clk = ~clk;

  multicycle_main_control #(.OPC_W(4), .FUNC_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_branch(pc_branch), .pc_jump(pc_jump),
    .pc_jr(pc_jr), .reg_write(reg_write), .link(link), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .state_o(state_o), .retired(retired)
  );

  multicycle_main_control #(.OPC_W(4), .FUNC_W(6), .CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_op(sAluOp), .mem_req(sMemReq), .mem_we(sMemWe), .iord(sIord),
    .ir_write(sIrWrite), .pc_inc(sPcInc), .pc_branch(sPcBranch), .pc_jump(sPcJump),
    .pc_jr(sPcJr), .reg_write(sRegWrite), .link(sLink), .mem_to_reg(sMemToReg),
    .illegal_op(sIllegalOp), .state_o(sState), .retired(sRetired)
  );

  logic [18:0] dutVec, smallVec;
  assign dutVec   = {alu_op, mem_req, mem_we, iord, ir_write, pc_inc, pc_branch, pc_jump, pc_jr,
                     reg_write, link, mem_to_reg, illegal_op, state_o};
  assign smallVec = {sAluOp, sMemReq, sMemWe, sIord, sIrWrite, sPcInc, sPcBranch, sPcJump, sPcJr,
                     sRegWrite, sLink, sMemToReg, sIllegalOp, sState};

  typedef struct {
    logic [18:0] outs;
    logic        memReady;
    logic        aluZero;
  } cyc_t;

  cyc_t        q[$];
  int          passCnt = 0;
  int          totalCnt = 0;
  int          retCount = 0;
  int          nCycles;
  logic [31:0] stLog;
  bit          sawBr, sawJmp, sawJr, sawIll, sawLink;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [18:0] pk(input logic [3:0] op, input logic memReq, input logic memWe,
      input logic ad, input logic irW, input logic pcI, input logic pcB, input logic pcJ,
      input logic pcR, input logic regW, input logic lnk, input logic m2r, input logic ill,
      input logic [2:0] st);
    return {op, memReq, memWe, ad, irW, pcI, pcB, pcJ, pcR, regW, lnk, m2r, ill, st};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expand one instruction into its expected cycle trace; returns whether it retires.
  task automatic build(input logic [3:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, output bit retires);
    bit ill, jmp, jr, br;
    retires = 1'b1;
    for (int i = 0; i < fw; i++) q.push_back('{pk(4'h1,1,0,0,0,0,0,0,0,0,0,0,0,3'd0), 1'b0, rb()});
    q.push_back('{pk(4'h1,1,0,0,1,1,0,0,0,0,0,0,0,3'd0), 1'b1, rb()});
    ill = (op >= 4'd11);
    jmp = (op == 4'd7 || op == 4'd8);
    jr  = (op == 4'd0 && fn == 6'h08);
    q.push_back('{pk(op,0,0,0,0,0,0,jmp & !ill,jr,op == 4'd8,op == 4'd8,0,ill,3'd1), rb(), rb()});
    if (ill) begin retires = 1'b0; return; end
    if (jmp || jr) return;
    br = (op == 4'd4) ? z : (op == 4'd5) ? !z : 1'b0;
    q.push_back('{pk(op,0,0,0,0,0,br,0,0,0,0,0,0,3'd2), rb(), z});
    if (op == 4'd4 || op == 4'd5) return;
    if (op == 4'd2 || op == 4'd3) begin
      for (int i = 0; i < mw; i++)
        q.push_back('{pk(op,1,op == 4'd3,1,0,0,0,0,0,0,0,0,0,3'd3), 1'b0, rb()});
      q.push_back('{pk(op,1,op == 4'd3,1,0,0,0,0,0,0,0,0,0,3'd3), 1'b1, rb()});
      if (op == 4'd3) return;
    end
    q.push_back('{pk(op,0,0,0,0,0,0,0,0,1,0,op == 4'd2,0,3'd4), rb(), rb()});
  endtask

  task automatic runInstr(input logic [3:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw);
    bit   retires;
    cyc_t c;
    q.delete();
    build(op, fn, z, fw, mw, retires);
    nCycles = 0;
    stLog   = '0;
    {sawBr, sawJmp, sawJr, sawIll, sawLink} = '0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      opcode    = op;
      func      = fn;
      mem_ready = c.memReady;
      alu_zero  = c.aluZero;
      #1;
      check("outputs", 32'(dutVec), 32'(c.outs));
      check("outputs_small", 32'(smallVec), 32'(c.outs));
      check("retired", 32'(retired), 32'(retCount[15:0]));
      check("retired_small", 32'(sRetired), 32'(retCount[3:0]));
      check("pc_onehot", 32'($countones({pc_inc, pc_branch, pc_jump, pc_jr}) <= 1), 32'd1);
      stLog   = (stLog << 3) | 32'(state_o);
      nCycles++;
      sawBr   |= pc_branch;
      sawJmp  |= pc_jump;
      sawJr   |= pc_jr;
      sawIll  |= illegal_op;
      sawLink |= link;
    end
    if (retires) retCount++;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; func = '0; mem_ready = 1'b0; alu_zero = 1'b0;
    #3;
    check("reset_outputs_zero", 32'(dutVec), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_state", 32'(state_o), 32'd0);
    check("post_reset_mem_req", 32'(mem_req), 32'd1);
    check("post_reset_alu_op", 32'(alu_op), 32'd1);

    // add: FETCH, DECODE, EXEC, WB, then FETCH with one retirement
    runInstr(4'd0, 6'h20, 1'b0, 0, 0);
    check("add_cycles", 32'(nCycles), 32'd4);
    check("add_states", stLog, 32'o0124);
    afterEdge();
    check("add_back_to_fetch", 32'(state_o), 32'd0);
    check("add_retired", 32'(retired), 32'd1);

    // lw with two wait cycles in MEM
    runInstr(4'd2, 6'h00, 1'b0, 0, 2);
    check("lw_cycles", 32'(nCycles), 32'd7);
    check("lw_states", stLog, 32'o0123334);

    runInstr(4'd4, 6'h00, 1'b1, 0, 0);
    check("beq_taken", 32'(sawBr), 32'd1);
    check("beq_states", stLog, 32'o012);
    runInstr(4'd5, 6'h00, 1'b1, 1, 0);
    check("bne_not_taken", 32'(sawBr), 32'd0);
    check("bne_cycles", 32'(nCycles), 32'd4);

    runInstr(4'd8, 6'h00, 1'b0, 0, 0);
    check("jal_jump", 32'({sawJmp, sawLink, sawJr}), 32'b110);
    runInstr(4'd0, 6'h08, 1'b0, 0, 0);
    check("jr_only", 32'({sawJr, sawJmp, sawBr}), 32'b100);
    runInstr(4'd12, 6'h00, 1'b0, 0, 0);
    check("illegal_seen", 32'(sawIll), 32'd1);
    check("illegal_cycles", 32'(nCycles), 32'd2);
    afterEdge();
    check("illegal_retired_unchanged", 32'(retired), 32'd6);

    // Ten jumps bring the count to 16: the 4-bit counter wraps to zero
    for (int i = 0; i < 10; i++) runInstr(4'd7, 6'($urandom), rb(), 0, 0);
    afterEdge();
    check("wrap_small", 32'(sRetired), 32'd0);
    check("wrap_main", 32'(retired), 32'd16);

    // Reset in the middle of a sw memory access
    @(negedge clk); opcode = 4'd3; func = '0; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("sw_in_mem", 32'({state_o, mem_we, mem_req}), 32'({3'd3, 1'b1, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_mem_reset_zero", 32'(dutVec), 32'd0);
    check("mid_mem_reset_retired", 32'({retired, sRetired}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_mem_release", 32'({state_o, mem_req, retired}), 32'({3'd0, 1'b1, 16'd0}));
    retCount = 0;

    for (int n = 0; n < 300; n++) begin
      logic [5:0] fn;
      fn = ($urandom_range(2) == 0) ? 6'h08 : 6'($urandom);
      runInstr(4'($urandom), fn, rb(), $urandom_range(2), $urandom_range(2));
    end
    afterEdge();
    check("final_retired", 32'(retired), 32'(retCount[15:0]));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
